// File: rtl/dcache_port_arbiter_pkg.sv
// Shared cache definitions: request-tag field encodings and the port-arbiter state set.
package dcache_port_arbiter_pkg;

  localparam logic [1:0] READ   = 2'b01;
  localparam logic [1:0] WRITE  = 2'b10;
  localparam logic [1:0] MEMORY = 2'b01;
  localparam logic [1:0] DATA   = 2'b01;

  typedef enum logic [1:0] {StIdle, StReq, StRdWait, StWrWait} arbState_e;

  // Tag layout: {type, MEMORY, DATA, 7'b0}.
  function automatic logic [12:0] makeTag(input logic isWrite);
    return {(isWrite ? WRITE : READ), MEMORY, DATA, 7'b0};
  endfunction

endpackage

// File: rtl/dcache_grant_select.sv
// Write-favouring grant between the read and write ports, with a read-starvation limit.
module dcache_grant_select #(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rdReq,
  input  logic wrReq,
  input  logic grantEn,
  output logic grantRd,
  output logic grantWr
);

  localparam int unsigned CntW = $clog2(STARVE_LIM + 2);

  logic [CntW-1:0] starveCntQ;
  logic            readDue;

  assign readDue = (starveCntQ == CntW'(STARVE_LIM));
  assign grantWr = grantEn && wrReq && !(rdReq && readDue);
  assign grantRd = grantEn && rdReq && !grantWr;

  // Counts write grants that overtook a waiting read; saturates because a due read always wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCntQ <= '0;
    end else if (!rdReq || grantRd) begin
      starveCntQ <= '0;
    end else if (grantWr && !readDue) begin
      starveCntQ <= starveCntQ + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the Memory-stage read port and WriteBack write port onto one dCache master port,
// one transaction outstanding at a time.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_reqcyc,
  input  logic [63:0] rd_addr,
  output logic        rd_reqack,
  output logic        rd_respcyc,
  output logic [63:0] rd_resp,
  input  logic        rd_respack,
  input  logic        wr_reqcyc,
  input  logic [63:0] wr_addr,
  input  logic [63:0] wr_data,
  output logic        wr_reqack,
  output logic        wr_writeack,
  input  logic        flush_in,
  output logic        busy_out,
  output logic        m_reqcyc,
  output logic [63:0] m_req,
  output logic [63:0] m_reqdata,
  output logic [12:0] m_reqtag,
  output logic        m_respack,
  input  logic        m_reqack,
  input  logic        m_respcyc,
  input  logic [63:0] m_resp,
  input  logic        m_writeack
);

  arbState_e   stateQ, stateD;
  logic        grantRd, grantWr;
  logic        isWrQ;
  logic        dropQ, dropD, dropNow, flushHit;
  logic [63:0] addrQ, dataQ;
  logic [12:0] tagQ;

  dcache_grant_select #(
    .STARVE_LIM(STARVE_LIM)
  ) uGrant (
    .clk    (clk),
    .reset  (reset),
    .rdReq  (rd_reqcyc),
    .wrReq  (wr_reqcyc),
    .grantEn(stateQ == StIdle),
    .grantRd(grantRd),
    .grantWr(grantWr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:   if (grantRd || grantWr) stateD = StReq;
      StReq:    if (m_reqack) stateD = isWrQ ? StWrWait : StRdWait;
      StRdWait: if (m_respcyc && m_respack) stateD = StIdle;
      StWrWait: if (m_writeack) stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  // A flush kills the read's data in the same cycle it arrives; writes are never dropped.
  assign flushHit = flush_in && !isWrQ && (stateQ == StReq || stateQ == StRdWait);
  assign dropNow  = dropQ || flushHit;
  assign dropD    = (stateD == StIdle) ? 1'b0 : dropNow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropQ <= 1'b0;
      isWrQ <= 1'b0;
      addrQ <= '0;
      dataQ <= '0;
      tagQ  <= '0;
    end else begin
      dropQ <= dropD;
      if (grantRd || grantWr) begin
        isWrQ <= grantWr;
        addrQ <= grantWr ? wr_addr : rd_addr;
        dataQ <= grantWr ? wr_data : '0;
        tagQ  <= makeTag(grantWr);
      end
    end
  end

  assign m_req     = addrQ;
  assign m_reqdata = dataQ;
  assign m_reqtag  = tagQ;

  always_comb begin
    m_reqcyc    = 1'b0;
    m_respack   = 1'b0;
    rd_reqack   = 1'b0;
    wr_reqack   = 1'b0;
    rd_respcyc  = 1'b0;
    rd_resp     = '0;
    wr_writeack = 1'b0;
    busy_out    = 1'b1;
    unique case (stateQ)
      StIdle: busy_out = 1'b0;
      StReq: begin
        m_reqcyc  = 1'b1;
        rd_reqack = m_reqack && !isWrQ;
        wr_reqack = m_reqack && isWrQ;
      end
      StRdWait: begin
        rd_respcyc = m_respcyc && !dropNow;
        rd_resp    = dropNow ? '0 : m_resp;
        m_respack  = dropNow || rd_respack;
      end
      StWrWait: wr_writeack = m_writeack;
      default:  busy_out = 1'b0;
    endcase
  end

endmodule

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIM, 4, consecutive write grants allowed while a read waits.
REQ-002 SHALL have port: clk  in  1  sole clock; all state on posedge.
REQ-003 SHALL have port: reset  in  1  reset, asynchronous and active-low (0 = reset).
REQ-004 SHALL have port: rd_reqcyc  in  1  Memory-stage read request; level, held until rd_reqack.
REQ-005 SHALL have port: rd_addr  in  64  read address, stable while rd_reqcyc=1.
REQ-006 SHALL have port: rd_reqack  out  1  one-cycle pulse; read accepted downstream.
REQ-007 SHALL have port: rd_respcyc  out  1  read data valid to requester.
REQ-008 SHALL have port: rd_resp  out  64  read data.
REQ-009 SHALL have port: rd_respack  in  1  requester consumed rd_resp.
REQ-010 SHALL have port: wr_reqcyc  in  1  WriteBack write request; level, held until wr_reqack.
REQ-011 SHALL have port: wr_addr  in  64  write address.
REQ-012 SHALL have port: wr_data  in  64  write data.
REQ-013 SHALL have port: wr_reqack  out  1  one-cycle pulse; write accepted downstream.
REQ-014 SHALL have port: wr_writeack  out  1  one-cycle pulse; write committed.
REQ-015 SHALL have port: flush_in  in  1  pipeline kill; discard data of in-flight read.
REQ-016 SHALL have port: busy_out  out  1  transaction in flight (core_memaccess_inprogress source).
REQ-017 SHALL have ports m_reqcyc/m_req(64)/m_reqdata(64)/m_reqtag(13)/m_respack out and m_reqack/m_respcyc/m_resp(64)/m_writeack in, forming the dCache CacheCoreInterface master side.

Function
REQ-018 SHALL run FSM IDLE -> REQ -> (RD_WAIT | WR_WAIT) -> IDLE, one transaction outstanding.
REQ-019 IDLE: SHALL grant on a cycle with any request; latch winner's address/data/type; next state REQ.
REQ-020 Arbitration SHALL favour write; read wins if write absent or starve_cnt == STARVE_LIM.
REQ-021 starve_cnt SHALL increment on each write grant while rd_reqcyc=1, clear on read grant or rd_reqcyc=0, saturate at STARVE_LIM.
REQ-022 REQ: m_reqcyc=1 with latched fields; m_reqtag = {WRITE,MEMORY,DATA,7'b0} or {READ,MEMORY,DATA,7'b0}.
REQ-023 On m_reqack=1 in REQ: pulse winner's reqack same cycle (combinational), drop m_reqcyc next cycle, go RD_WAIT or WR_WAIT.
REQ-024 RD_WAIT: forward m_respcyc/m_resp to rd_respcyc/rd_resp; m_respack = rd_respack; exit to IDLE on m_respcyc & m_respack.
REQ-025 WR_WAIT: wr_writeack = m_writeack; exit to IDLE when m_writeack=1.
REQ-026 flush_in in REQ or RD_WAIT SHALL set a drop flag: transaction still completes downstream, rd_respcyc held 0, arbiter self-asserts m_respack; flag clears on IDLE entry.
REQ-027 flush_in SHALL never abort a write once granted.
REQ-028 busy_out SHALL be 1 in REQ, RD_WAIT, WR_WAIT; 0 in IDLE.
REQ-029 Minimum latency SHALL be grant cycle + 1 cycle to m_reqcyc; back-to-back transactions need one IDLE cycle between.
REQ-030 m_writeack or m_respcyc arriving in a non-matching state SHALL be ignored.

Reset
REQ-031 On reset=0: state IDLE, starve_cnt 0, drop flag 0; m_reqcyc, m_respack, rd_reqack, wr_reqack, rd_respcyc, wr_writeack, busy_out all 0; m_req/m_reqdata/m_reqtag/rd_resp 0.
REQ-032 Reset mid-transaction SHALL abandon it without pulsing any ack; first grant possible on the cycle after reset release.

Structure
REQ-033 Tag field constants (READ, WRITE, MEMORY, DATA) and the state enum SHALL come from the shared cache package; none redefined locally.
REQ-034 One sub-module, dcache_grant_select (priority + starvation counter), is natural; the remainder is flat.

Verification
REQ-035 Read only: rd_addr=0x1000, reqack after 2 cycles, resp 0xDEAD after 3 more -> rd_resp=0xDEAD, single rd_reqack pulse, busy_out 0 after respack.
REQ-036 Simultaneous rd/wr in IDLE -> write granted first (m_reqtag WRITE, m_reqdata=wr_data), read granted on the following IDLE.
REQ-037 Continuous writes with read pending -> read granted after exactly 4 write grants.
REQ-038 flush_in one cycle after read m_reqack -> rd_respcyc stays 0, m_respack asserted by arbiter, FSM returns IDLE.
REQ-039 reset=0 asserted in WR_WAIT -> all outputs 0 immediately, no wr_writeack pulse, new grant works after release.
